// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - programmable clock-divider controller with boundary-synchronous ratio change
module clkdiv_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  output logic         div_ack,
  output logic         div_err,
  output logic         busy,
  output logic [W-1:0] cur_div,
  output logic         div_out,
  output logic         tick
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [W-1:0] ONE   = 1;
  localparam logic [W:0]   ONE_X = 1;
  localparam logic [W-1:0] DEF   = W'(DEFAULT_DIV);

  state_t         state, state_n;
  logic [1:0]     rst_sync;
  logic           rst_n;
  logic [W-1:0]   cnt, cnt_n, pend, pend_n, div_n, take;
  logic           busy_n, ack_n, err_n, div_out_n, tick_n;
  logic           last, boundary, accept, apply;
  logic [W:0]     half;

  // Assertion is immediate; release is delayed two edges to avoid metastable deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      cur_div <= DEF;
      busy    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      cur_div <= div_n;
      busy    <= busy_n;
      div_ack <= ack_n;
      div_err <= err_n;
      div_out <= div_out_n;
      tick    <= tick_n;
    end
  end

  always_comb begin
    last    = (state == RUN) && (cnt == cur_div - ONE);
    state_n = state;
    case (state)
      IDLE:    state_n = en ? RUN : IDLE;
      RUN:     state_n = (last && !en) ? IDLE : RUN;
      default: state_n = IDLE;
    endcase
    cnt_n = (state == RUN && !last) ? cnt + ONE : '0;
  end

  // A request arriving in a boundary cycle bypasses the pending register and applies at once.
  always_comb begin
    boundary  = (state == IDLE) || last;
    accept    = div_req && !busy && !div_ack;
    take      = accept ? div_val : pend;
    apply     = boundary && (accept || busy);
    pend_n    = accept ? div_val : pend;
    div_n     = (apply && take != '0) ? take : cur_div;
    busy_n    = (accept || busy) && !apply;
    ack_n     = apply;
    err_n     = apply && (take == '0);
    half      = ({1'b0, div_n} + ONE_X) >> 1;
    div_out_n = (state_n == RUN) && ({1'b0, cnt_n} < half);
    tick_n    = (state_n == RUN) && (cnt_n == div_n - ONE);
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - directed self-checking bench for clkdiv_ctrl
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, div_req;
  logic [7:0] div_val;
  logic       div_ack, div_err, busy, div_out, tick;
  logic [7:0] cur_div;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int e3_out[6]  = '{1, 1, 0, 1, 1, 0};
  int e3_tick[6] = '{0, 0, 1, 0, 0, 1};
  int e5_out[4]  = '{1, 1, 0, 0};
  int e5_tick[4] = '{0, 0, 0, 1};

  clkdiv_ctrl #(.W(8), .DEFAULT_DIV(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .busy    (busy),
    .cur_div (cur_div),
    .div_out (div_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag, input logic [31:0] exp_div);
    chk({tag, "_div_out"}, 32'(div_out), 0);
    chk({tag, "_tick"},    32'(tick),    0);
    chk({tag, "_ack"},     32'(div_ack), 0);
    chk({tag, "_err"},     32'(div_err), 0);
    chk({tag, "_busy"},    32'(busy),    0);
    chk({tag, "_cur_div"}, 32'(cur_div), exp_div);
  endtask

  initial begin
    int highs, ticks, bad, acks;
    reset = 1'b0; en = 1'b0; div_req = 1'b0; div_val = 8'd0;
    repeat (3) step();
    chk_idle_outs("reset", 3);
    reset = 1'b1;
    repeat (4) step();
    chk_idle_outs("post_release", 3);

    // divide by 3 from reset default
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("n3_out_%0d", i),  32'(div_out), 32'(e3_out[i]));
      chk($sformatf("n3_tick_%0d", i), 32'(tick),    32'(e3_tick[i]));
    end
    chk("n3_cur_div", 32'(cur_div), 3);

    // request 4 in the cnt=0 cycle
    step();
    chk("c7_out", 32'(div_out), 1);
    div_req = 1'b1; div_val = 8'd4;
    step();
    chk("r4_busy1", 32'(busy), 1);
    chk("r4_noack1", 32'(div_ack), 0);
    step();
    chk("r4_busy2", 32'(busy), 1);
    chk("r4_tick_old", 32'(tick), 1);
    chk("r4_out_old", 32'(div_out), 0);
    step();
    chk("r4_ack", 32'(div_ack), 1);
    chk("r4_err", 32'(div_err), 0);
    chk("r4_busy_clr", 32'(busy), 0);
    chk("r4_cur_div", 32'(cur_div), 4);
    chk("r4_out0", 32'(div_out), 1);
    div_req = 1'b0;
    step();
    chk("r4_ack_pulse", 32'(div_ack), 0);
    chk("r4_out1", 32'(div_out), 1);
    step();
    chk("r4_out2", 32'(div_out), 0);
    chk("r4_tick2", 32'(tick), 0);
    step();
    chk("r4_out3", 32'(div_out), 0);
    chk("r4_tick3", 32'(tick), 1);

    // request 5 inside a tick cycle
    div_req = 1'b1; div_val = 8'd5;
    step();
    chk("r5_ack", 32'(div_ack), 1);
    chk("r5_busy", 32'(busy), 0);
    chk("r5_cur_div", 32'(cur_div), 5);
    chk("r5_out0", 32'(div_out), 1);
    div_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("r5_out_%0d", i + 1),  32'(div_out), 32'(e5_out[i]));
      chk($sformatf("r5_tick_%0d", i + 1), 32'(tick),    32'(e5_tick[i]));
    end

    // zero divisor is rejected
    step();
    div_req = 1'b1; div_val = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("r0_out_%0d", i + 1), 32'(div_out), 32'(e5_out[i]));
      chk($sformatf("r0_busy_%0d", i + 1), 32'(busy), 1);
    end
    step();
    chk("r0_ack", 32'(div_ack), 1);
    chk("r0_err", 32'(div_err), 1);
    chk("r0_cur_div", 32'(cur_div), 5);
    chk("r0_out0", 32'(div_out), 1);
    div_req = 1'b0;
    step();
    chk("r0_ack_clr", 32'(div_ack), 0);
    chk("r0_err_clr", 32'(div_err), 0);
    chk("r0_out1", 32'(div_out), 1);

    // divide by 1
    div_req = 1'b1; div_val = 8'd1;
    repeat (3) step();
    chk("r1_old_tick", 32'(tick), 1);
    step();
    chk("r1_ack", 32'(div_ack), 1);
    chk("r1_cur_div", 32'(cur_div), 1);
    div_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("n1_out_%0d", i), 32'(div_out), 1);
      chk($sformatf("n1_tick_%0d", i), 32'(tick), 1);
    end

    // divide by 255
    div_req = 1'b1; div_val = 8'd255;
    step();
    chk("r255_ack", 32'(div_ack), 1);
    chk("r255_cur_div", 32'(cur_div), 255);
    div_req = 1'b0;
    highs = 0; ticks = 0; bad = 0;
    for (int i = 0; i < 255; i++) begin
      if (div_out === 1'b1) highs++;
      if (tick === 1'b1) ticks++;
      if (div_out !== (i < 128) || tick !== (i == 254)) bad++;
      if (i < 254) step();
    end
    chk("n255_highs", 32'(highs), 128);
    chk("n255_ticks", 32'(ticks), 1);
    chk("n255_pattern_bad", 32'(bad), 0);

    // back to 5, then drop en at cnt=1
    div_req = 1'b1; div_val = 8'd5;
    step();
    chk("d5_ack", 32'(div_ack), 1);
    div_req = 1'b0;
    step();
    en = 1'b0;
    step();
    chk("dis_out2", 32'(div_out), 1);
    step();
    chk("dis_out3", 32'(div_out), 0);
    step();
    chk("dis_tick4", 32'(tick), 1);
    step();
    chk("dis_idle_out", 32'(div_out), 0);
    chk("dis_idle_tick", 32'(tick), 0);
    step();
    chk("dis_idle_out2", 32'(div_out), 0);

    // change while idle acks next cycle
    div_req = 1'b1; div_val = 8'd4;
    step();
    chk("idle_ack", 32'(div_ack), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cur_div", 32'(cur_div), 4);
    chk("idle_out", 32'(div_out), 0);
    div_req = 1'b0;

    // reset with a request pending
    en = 1'b1;
    step();
    chk("rst_run_out", 32'(div_out), 1);
    div_req = 1'b1; div_val = 8'd7;
    step();
    chk("rst_pend_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_idle_outs("rst_async", 3);
    repeat (2) step();
    div_req = 1'b0; en = 1'b0;
    reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (div_ack === 1'b1) acks++;
    end
    chk("rst_no_ack", 32'(acks), 0);
    chk_idle_outs("rst_after", 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
